// File: rtl/ewb_ctrl_pkg.sv
// Shared types and helpers for the eviction write buffer controller.
// The line compare ignores the byte offset inside a cacheline.
package ewb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP     = 2'd1,
        MEM_READ = 2'd2,
        DRAIN    = 2'd3
    } ewb_state_t;

    localparam int LINE_OFFSET_BITS = 4;
    localparam int MAX_ADDR_W       = 64;

    // Callers size-cast their addresses up to MAX_ADDR_W before comparing.
    function automatic logic line_match(input logic [MAX_ADDR_W-1:0] a,
                                        input logic [MAX_ADDR_W-1:0] b);
        return (a >> LINE_OFFSET_BITS) == (b >> LINE_OFFSET_BITS);
    endfunction

endpackage

// File: rtl/ewb_controller_if.sv
// Cache, memory and EWB-storage signals seen by the EWB controller.
// cache_wdata goes straight to the EWB storage, so the controller modport omits it.
interface ewb_controller_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) ();

    logic              cache_read;
    logic              cache_write;
    logic [ADDR_W-1:0] cache_address;
    logic [LINE_W-1:0] cache_wdata;
    logic [LINE_W-1:0] cache_rdata;
    logic              cache_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    logic              ewb_load;
    logic [ADDR_W-1:0] ewb_address;
    logic [LINE_W-1:0] ewb_data;

    // Controller side.
    modport slave (
        input  cache_read, cache_write, cache_address,
        input  mem_rdata, mem_resp,
        input  ewb_address, ewb_data,
        output cache_rdata, cache_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        output ewb_load
    );

    // Surrounding cache, memory port and EWB storage.
    modport master (
        output cache_read, cache_write, cache_address, cache_wdata,
        output mem_rdata, mem_resp,
        output ewb_address, ewb_data,
        input  cache_rdata, cache_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        input  ewb_load
    );

endinterface

// File: rtl/ewb_controller.sv
// Sequences a single-entry eviction write buffer: reads go to memory ahead of the write-back; buffer hits are served locally.
// Latency: evict/hit 1 cycle, miss mem+1, conflicting evict mem+2; cache requests stall (held) while a drain or miss is in flight.
module ewb_controller
    import ewb_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 128
) (
    input  logic           clk,
    input  logic           rst,
    ewb_controller_if.slave bus
);

    ewb_state_t        state_q, state_d;
    logic              valid_q, valid_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              addr_hit;
    logic              ewb_load;

    assign addr_hit = line_match(MAX_ADDR_W'(bus.cache_address),
                                 MAX_ADDR_W'(bus.ewb_address));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    // A read always wins over a simultaneous write; the write is re-seen later.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        rdata_d  = rdata_q;
        ewb_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cache_read) begin
                    if (valid_q && addr_hit) begin
                        rdata_d = bus.ewb_data;
                        state_d = RESP;
                    end else begin
                        state_d = MEM_READ;
                    end
                end else if (bus.cache_write) begin
                    if (!valid_q || addr_hit) begin
                        ewb_load = 1'b1;
                        valid_d  = 1'b1;
                        state_d  = RESP;
                    end else begin
                        state_d = DRAIN;
                    end
                end else if (valid_q) begin
                    state_d = DRAIN;
                end
            end
            MEM_READ: begin
                if (bus.mem_resp) begin
                    rdata_d = bus.mem_rdata;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                if (bus.mem_resp) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes decode straight from the state register so reset drops them at once.
    always_comb begin
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        case (state_q)
            MEM_READ: begin
                bus.mem_read    = 1'b1;
                bus.mem_address = bus.cache_address;
            end
            DRAIN: begin
                bus.mem_write   = 1'b1;
                bus.mem_address = bus.ewb_address;
            end
            default: begin
                bus.mem_read    = 1'b0;
                bus.mem_write   = 1'b0;
                bus.mem_address = '0;
            end
        endcase
    end

    assign bus.cache_resp  = (state_q == RESP);
    assign bus.cache_rdata = rdata_q;
    assign bus.mem_wdata   = bus.ewb_data;
    assign bus.ewb_load    = ewb_load;

    a_strobes_exclusive: assert property (
        @(posedge clk) disable iff (!rst) !(bus.mem_read && bus.mem_write)
    );

endmodule

// File: tb/tb_ewb_controller.sv
// Bench for ewb_controller: directed latency vectors, reset/drain sequences,
// and random traffic compared against a "last write wins" memory image.
module tb_ewb_controller;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ewb_controller_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

    ewb_controller #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_a(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Backing memory: lines never written return a fixed address-derived pattern.
    logic [LINE_W-1:0] mem [bit [27:0]];

    function automatic logic [LINE_W-1:0] init_line(input bit [27:0] l);
        logic [31:0] w;
        w = {4'hA, l};
        return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd1};
    endfunction

    function automatic logic [LINE_W-1:0] mem_get(input bit [27:0] l);
        if (mem.exists(l)) return mem[l];
        return init_line(l);
    endfunction

    // EWB storage instance that lives in the parent.
    always @(posedge clk) begin
        if (bus.ewb_load) begin
            bus.ewb_address <= bus.cache_address;
            bus.ewb_data    <= bus.cache_wdata;
        end
    end

    // Memory port: answers after mem_lat cycles of strobe, and checks bus rules each cycle.
    int mem_lat = 3;
    int rd_cnt  = 0;
    int wr_cnt  = 0;
    initial begin
        int cnt;
        cnt = 0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_resp) begin
                bus.mem_resp = 1'b0;
                cnt = 0;
            end else if (rst && (bus.mem_read || bus.mem_write)) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    bus.mem_resp = 1'b1;
                    if (bus.mem_read) begin
                        bus.mem_rdata = mem_get(bus.mem_address[31:4]);
                        rd_cnt++;
                    end else begin
                        mem[bus.mem_address[31:4]] = bus.mem_wdata;
                        wr_cnt++;
                    end
                end
            end else begin
                cnt = 0;
            end
            if (rst) begin
                chk_b("strobe_excl", bus.mem_read && bus.mem_write, 1'b0);
                if (!bus.mem_read && !bus.mem_write)
                    chk_a("addr_idle_zero", bus.mem_address, '0);
                if (bus.mem_write)
                    chk("wdata_is_ewb", bus.mem_wdata, bus.ewb_data);
            end
        end
    end

    // All request tasks start and end 1 time unit after a rising edge.
    task automatic do_req(input bit is_wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] d,
                          output int lat, output logic [LINE_W-1:0] rd, output logic load_n);
        bus.cache_read    = !is_wr;
        bus.cache_write   = is_wr;
        bus.cache_address = a;
        bus.cache_wdata   = d;
        lat    = -1;
        rd     = '0;
        load_n = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) load_n = bus.ewb_load;
            if (bus.cache_resp) begin
                lat = c;
                rd  = bus.cache_rdata;
                break;
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: no cache_resp for addr %h within 300 cycles", a);
        end
        @(posedge clk);
        #1;
        bus.cache_read  = 1'b0;
        bus.cache_write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for 8 consecutive cycles without memory strobes (buffer drained).
    task automatic wait_drained();
        int quiet;
        bit ok;
        quiet = 0;
        ok    = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            quiet = (bus.mem_read || bus.mem_write) ? 0 : quiet + 1;
            if (quiet >= 8) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: memory strobes still active after 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [ADDR_W-1:0] a1;
        logic [LINE_W-1:0] d1;
        bit                wr2;
        logic [ADDR_W-1:0] a2;
        logic [LINE_W-1:0] d2;
        logic [LINE_W-1:0] exp_rd;
        int                exp_lat;
        bit                exp_load;
        int                exp_rd_ops;
        int                exp_wr_ops;
        logic [ADDR_W-1:0] chk_a;
        logic [LINE_W-1:0] chk_d;
    } vec_t;

    localparam logic [LINE_W-1:0] LA0 = 128'hA0A0_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [LINE_W-1:0] LA1 = 128'hA1A1_0101_1212_2323_3434_4545_5656_6767;
    localparam logic [LINE_W-1:0] LA2 = 128'hA2A2_F00D_CAFE_BEEF_0000_1234_5678_9ABC;
    localparam logic [LINE_W-1:0] LA3 = 128'hA3A3_DEAD_0000_FFFF_1357_2468_ACE0_BDF1;
    localparam logic [LINE_W-1:0] LA4 = 128'hA4A4_1111_2222_3333_4444_5555_6666_7777;
    localparam logic [LINE_W-1:0] LA5 = 128'hA5A5_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
    localparam logic [LINE_W-1:0] LC  = 128'hC0C0_0123_4567_89AB_CDEF_FEDC_BA98_7654;
    localparam logic [LINE_W-1:0] LD  = 128'hD0D0_3141_5926_5358_9793_2384_6264_3383;
    localparam logic [LINE_W-1:0] LE  = 128'hE0E0_2718_2818_2845_9045_2353_6028_7471;
    localparam logic [LINE_W-1:0] LF  = 128'hF0F0_1414_2135_6237_3095_0488_0168_8724;
    localparam logic [LINE_W-1:0] LG  = 128'h6060_1732_0508_0756_8877_2935_2747_6340;
    localparam logic [LINE_W-1:0] LH  = 128'h7070_2236_0679_7749_9789_6964_6091_7366;

    vec_t vecs [7];
    logic [LINE_W-1:0] model [bit [27:0]];

    initial begin
        int lat;
        logic [LINE_W-1:0] rd;
        logic ld;
        int rd0, wr0;
        bit got;

        // With mem_lat = 3: miss = 4 cycles, conflicting evict = 5 cycles.
        vecs[0] = '{32'h1000, LA1, 1'b0, 32'h100C, '0,  LA1,                 1, 1'b0, 0, 0, 32'h1000, LA1};
        vecs[1] = '{32'h1000, LA2, 1'b0, 32'h2000, '0,  init_line(28'h200),  4, 1'b0, 1, 0, 32'h1000, LA2};
        vecs[2] = '{32'h1000, LA3, 1'b1, 32'h3000, LC,  '0,                  5, 1'b0, 0, 1, 32'h3000, LC};
        vecs[3] = '{32'h1000, LA4, 1'b1, 32'h1008, LA5, '0,                  1, 1'b1, 0, 0, 32'h1000, LA5};
        vecs[4] = '{32'h4000, LD,  1'b0, 32'h4004, '0,  LD,                  1, 1'b0, 0, 0, 32'h4000, LD};
        vecs[5] = '{32'h5000, LE,  1'b0, 32'h1000, '0,  LA5,                 4, 1'b0, 1, 0, 32'h5000, LE};
        vecs[6] = '{32'h6000, LF,  1'b1, 32'h6000, LG,  '0,                  1, 1'b1, 0, 0, 32'h6000, LG};

        bus.cache_read    = 1'b0;
        bus.cache_write   = 1'b0;
        bus.cache_address = '0;
        bus.cache_wdata   = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        chk_b("rst_cache_resp", bus.cache_resp, 1'b0);
        chk("rst_cache_rdata", bus.cache_rdata, '0);
        chk_b("rst_mem_read", bus.mem_read, 1'b0);
        chk_b("rst_mem_write", bus.mem_write, 1'b0);
        chk_a("rst_mem_address", bus.mem_address, '0);
        chk_b("rst_ewb_load", bus.ewb_load, 1'b0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        // Free-slot eviction, then an opportunistic drain one cycle after going idle.
        do_req(1'b1, 32'h1000, LA0, lat, rd, ld);
        chk_i("seq1_lat", lat, 1);
        chk_b("seq1_load", ld, 1'b1);
        @(negedge clk);
        chk_b("seq1_no_drain_yet", bus.mem_write, 1'b0);
        @(negedge clk);
        chk_b("seq1_drain_write", bus.mem_write, 1'b1);
        chk_a("seq1_drain_addr", bus.mem_address, 32'h1000);
        chk("seq1_drain_data", bus.mem_wdata, LA0);
        @(posedge clk);
        #1;
        wait_drained();
        chk("seq1_mem_image", mem_get(28'h100), LA0);

        // Two-request vectors from an empty buffer.
        for (int i = 0; i < 7; i++) begin
            wait_drained();
            do_req(1'b1, vecs[i].a1, vecs[i].d1, lat, rd, ld);
            chk_i($sformatf("vec%0d_w1_lat", i), lat, 1);
            chk_b($sformatf("vec%0d_w1_load", i), ld, 1'b1);
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            do_req(vecs[i].wr2, vecs[i].a2, vecs[i].d2, lat, rd, ld);
            chk_i($sformatf("vec%0d_op2_lat", i), lat, vecs[i].exp_lat);
            chk_b($sformatf("vec%0d_op2_load", i), ld, vecs[i].exp_load);
            chk_i($sformatf("vec%0d_mem_reads", i), rd_cnt - rd0, vecs[i].exp_rd_ops);
            chk_i($sformatf("vec%0d_mem_writes", i), wr_cnt - wr0, vecs[i].exp_wr_ops);
            if (!vecs[i].wr2)
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
            wait_drained();
            chk($sformatf("vec%0d_mem_image", i), mem_get(vecs[i].chk_a[31:4]), vecs[i].chk_d);
        end

        // Reset in the middle of a drain discards the buffered line.
        wait_drained();
        do_req(1'b1, 32'h7000, LH, lat, rd, ld);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.mem_write) begin
                got = 1'b1;
                break;
            end
        end
        chk_b("rstd_drain_seen", got, 1'b1);
        #2 rst = 1'b0;
        #1;
        chk_b("rstd_write_drop", bus.mem_write, 1'b0);
        chk_a("rstd_addr_zero", bus.mem_address, '0);
        chk("rstd_rdata_clear", bus.cache_rdata, '0);
        #1 rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_b("rstd_quiet", bus.mem_read || bus.mem_write || bus.cache_resp, 1'b0);
        end
        @(posedge clk);
        #1;
        chk("rstd_line_lost", mem_get(28'h700), init_line(28'h700));
        do_req(1'b0, 32'h7000, '0, lat, rd, ld);
        chk_i("rstd_read_miss_lat", lat, 4);
        chk("rstd_read_from_mem", rd, init_line(28'h700));

        // Random traffic: every read must see the most recent eviction to its line.
        wait_drained();
        for (int i = 0; i < 300; i++) begin
            bit                wr;
            bit [27:0]         line;
            logic [ADDR_W-1:0] a;
            logic [LINE_W-1:0] d;
            idle($urandom_range(0, 3));
            mem_lat = $urandom_range(1, 4);
            wr   = 1'($urandom_range(0, 1));
            line = 28'h800 + 28'($urandom_range(0, 7));
            a    = {line, 4'($urandom)};
            d    = {$urandom, $urandom, $urandom, $urandom};
            do_req(wr, a, d, lat, rd, ld);
            if (lat < 0) continue;
            chk_b("rand_lat_bound", (lat >= 1) && (lat <= 12), 1'b1);
            if (wr)
                model[line] = d;
            else
                chk("rand_rdata", rd, model.exists(line) ? model[line] : init_line(line));
        end
        wait_drained();
        foreach (model[k])
            chk("rand_mem_image", mem_get(k), model[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time (checks %0d, errors %0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ewb_controller.md
# ewb_controller

Sequencing controller for the eviction write buffer (EWB) between the cache and the cacheline memory port. Dirty evictions are accepted into the single-entry EWB in one cycle, and read misses go to memory ahead of the write-back. The buffered line drains to memory only when the cache is idle or a second eviction needs the slot. Reads that hit the buffered address are served straight from the EWB, which keeps the buffer coherent.

## Interface
Parameters:
- ADDR_W, 32, address width (line-aligned; low 4 bits ignored in compare)
- LINE_W, 128, cacheline width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cache_read  in  1  read-miss request, held until cache_resp
- cache_write  in  1  dirty-eviction request, held until cache_resp
- cache_address  in  ADDR_W  request address
- cache_wdata  in  LINE_W  evicted line (routed to EWB data_in externally)
- cache_rdata  out  LINE_W  registered read data
- cache_resp  out  1  one-cycle completion pulse
- mem_read  out  1  memory read strobe, held until mem_resp
- mem_write  out  1  memory write strobe, held until mem_resp
- mem_address  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  = ewb_data
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp
- mem_resp  in  1  one-cycle memory completion
- ewb_load  out  1  EWB load enable
- ewb_address  in  ADDR_W  EWB address_out
- ewb_data  in  LINE_W  EWB data_out

## Operation
- Internal state: FSM state, `valid` bit (EWB holds an undrained line), `rdata` register.
- States: IDLE, RESP, MEM_READ, DRAIN.
- IDLE transitions, in priority order:
  - cache_read and valid and addr match (bits [ADDR_W-1:4] equal): rdata <= ewb_data → RESP.
  - cache_read, otherwise: → MEM_READ.
  - cache_write and (!valid or addr match): ewb_load=1 (combinational, this cycle), valid <= 1 → RESP.
  - cache_write and valid and no match: → DRAIN.
  - No request and valid: → DRAIN (opportunistic).
  - Otherwise stay IDLE.
- cache_read and cache_write together is illegal. Read wins and the write is ignored for that cycle.
- MEM_READ: mem_read=1, mem_address=cache_address. On mem_resp: rdata <= mem_rdata → RESP.
- DRAIN: mem_write=1, mem_address=ewb_address. On mem_resp: valid <= 0 → IDLE. A pending cache request is re-evaluated in IDLE. DRAIN is never aborted; cache requests wait.
- RESP: cache_resp=1 for exactly one cycle → IDLE. Requests are ignored while in RESP.
- mem_address = 0 whenever both mem strobes are low.
- mem_read and mem_write are never high together.

## Timing
- Reset values: state=IDLE, valid=0, rdata=0. All outputs 0; mem_wdata follows ewb_data.
- Eviction accept with slot free: request in cycle N, ewb_load at N, cache_resp at N+1.
- Buffer-hit read: request N, cache_resp and cache_rdata valid at N+1.
- Memory read: mem_read from N+1. If mem_resp arrives at M, cache_resp comes at M+1.
- Eviction with slot occupied by a different address:
  - DRAIN from N+1 until mem_resp at M.
  - IDLE at M+1, ewb_load at M+1, cache_resp at M+2.
- Opportunistic drain starts one cycle after the cache goes idle with valid=1.
- Reset asserted mid-DRAIN or mid-MEM_READ: immediate return to IDLE and valid=0. The buffered dirty line is discarded and strobes drop asynchronously.
- cache_rdata holds its last value until the next capture.

## Structure
- Package `ewb_ctrl_pkg`:
  - `ewb_state_t` enum {IDLE, RESP, MEM_READ, DRAIN}
  - LINE_OFFSET_BITS=4 constant
  - `line_match()` function for the tag compare.
- No sub-module.
- The EWB storage stays a separate instance in the parent; this block drives only its load enable and reads its outputs.

## Test plan
- Reset, then write 0x1000 with line A: ewb_load at N, cache_resp at N+1, valid=1. With no further request, mem_write to 0x1000 with data A begins; mem_resp clears valid.
- Write 0x1000 (A), then immediately read 0x100C: cache_resp one cycle later with rdata=A, and no mem_read issued.
- Write 0x1000 (A), then read 0x2000: mem_read to 0x2000 is issued before any mem_write. mem_resp with B gives cache_rdata=B; the drain of A follows.
- Write 0x1000 (A), then write 0x3000 (C): DRAIN of A to 0x1000, then C loaded. cache_resp for C occurs exactly 2 cycles after mem_resp.
- Write 0x1000 (A), then write 0x1008 (A'): overwrite in place, cache_resp at N+1, and no mem_write before the later drain writes A'.
- Assert rst mid-DRAIN: mem_write drops the same cycle, and after release state is IDLE with valid=0 and no mem traffic.
